// File: rtl/vga_pkg.sv
// Constants and state type shared by the VGA frame-buffer blocks (loader, controller, top level).
package vga_pkg;

   localparam int H_ACTIVE     = 640;
   localparam int V_ACTIVE     = 480;
   localparam int FRAME_PIXELS = H_ACTIVE * V_ACTIVE;
   localparam int ADDR_W       = 19;
   localparam int DATA_W       = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } loader_state_t;

endpackage

// File: rtl/frame_loader_if.sv
// Pixel stream (valid/ready) in and frame-memory write port out, as seen by the frame loader.
interface frame_loader_if #(
   parameter int DATA_W = vga_pkg::DATA_W,
   parameter int ADDR_W = vga_pkg::ADDR_W
);

   logic [DATA_W-1:0] s_data;
   logic              s_valid;
   logic              s_ready;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;

   modport master (
      output s_data, s_valid,
      input  s_ready, wr_en, wr_addr, wr_data
   );

   modport slave (
      input  s_data, s_valid,
      output s_ready, wr_en, wr_addr, wr_data
   );

endinterface

// File: rtl/frame_loader.sv
// Frame loader: takes one frame of raster-ordered grayscale bytes after a start pulse and
// writes them to the frame memory at addresses 0..H_ACTIVE*V_ACTIVE-1, one cycle after acceptance.
module frame_loader #(
   parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
   parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
   parameter int ADDR_W   = vga_pkg::ADDR_W,
   parameter int DATA_W   = vga_pkg::DATA_W
) (
   input  logic          clk_25,
   input  logic          rst,
   input  logic          start,
   frame_loader_if.slave bus,
   output logic          busy,
   output logic          done
);

   import vga_pkg::*;

   // Raster index y*H_ACTIVE+x is just the running beat count, so no multiplier is needed.
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

   loader_state_t     state_r;
   logic [ADDR_W-1:0] cnt_r;
   logic              wr_en_r;
   logic [ADDR_W-1:0] wr_addr_r;
   logic [DATA_W-1:0] wr_data_r;
   logic              busy_r;
   logic              done_r;
   logic              ready_s;
   logic              accept_s;

   // Ready depends on state alone; a beat is taken only while loading.
   always_comb begin
      ready_s  = (state_r == LOAD);
      accept_s = ready_s & bus.s_valid;
   end

   // Load FSM, pixel counter and registered write port.
   always_ff @(posedge clk_25) begin
      if (rst) begin
         state_r   <= IDLE;
         cnt_r     <= {ADDR_W{1'b0}};
         wr_en_r   <= 1'b0;
         wr_addr_r <= {ADDR_W{1'b0}};
         wr_data_r <= {DATA_W{1'b0}};
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         wr_en_r <= 1'b0;
         done_r  <= 1'b0;
         case (state_r)
            IDLE: begin
               if (start) begin
                  state_r <= LOAD;
                  busy_r  <= 1'b1;
                  cnt_r   <= {ADDR_W{1'b0}};
               end
            end
            LOAD: begin
               if (accept_s) begin
                  wr_en_r   <= 1'b1;
                  wr_addr_r <= cnt_r;
                  wr_data_r <= bus.s_data;
                  // The counter stops at the last address so it never wraps inside a frame.
                  if (cnt_r == LAST_ADDR) begin
                     state_r <= DONE;
                     done_r  <= 1'b1;
                  end else begin
                     cnt_r <= cnt_r + ADDR_W'(1);
                  end
               end
            end
            DONE: begin
               state_r <= IDLE;
               busy_r  <= 1'b0;
            end
            default: begin
               state_r <= IDLE;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.s_ready = ready_s;
   assign bus.wr_en   = wr_en_r;
   assign bus.wr_addr = wr_addr_r;
   assign bus.wr_data = wr_data_r;
   assign busy        = busy_r;
   assign done        = done_r;

endmodule
